// File: rtl/output_reg_arbiter_pkg.sv
// Shared types and constants for the output-register arbiter and its neighbours
// (output register, matrix unit).
package output_reg_arbiter_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot winner is the first set request
// found searching upward (with wrap) from pointer i_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [2*NUM_REQ-1:0] w_req2;
  logic [2*NUM_REQ-1:0] w_gnt2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_gnt;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_req2    = {i_req, i_req} >> i_ptr;
    w_rot     = w_req2[NUM_REQ-1:0];
    w_rot_gnt = w_rot & (~w_rot + NUM_REQ'(1));
    w_gnt2    = {NUM_REQ'(0), w_rot_gnt} << i_ptr;
    o_grant   = w_gnt2[2*NUM_REQ-1:NUM_REQ] | w_gnt2[NUM_REQ-1:0];
  end

endmodule

// File: rtl/output_reg_arbiter.sv
// Round-robin owner of the 4x4 output register: stages one requester's 16 words,
// then strobes write_data so the register captures the whole matrix at once.
module output_reg_arbiter
  import output_reg_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]   req_word,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        write_data,
  output logic [NUM_WORDS*WORD_W-1:0] data_to_write,
  output logic                        done,
  output logic                        busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_gnt_idx;
  logic [IDX_W-1:0]  r_ptr;
  logic [WORD_W-1:0] r_buf [NUM_WORDS];

  logic [NUM_REQ-1:0] w_win;
  logic [IDX_W-1:0]   w_win_idx;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [WORD_W-1:0]  w_words [NUM_REQ];
  logic [WORD_W-1:0]  w_word;
  logic               w_abort;
  logic               w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_win)
  );

  // Decode the winner, select the owner's word and qualify the handshake.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_win[i]) w_win_idx = IDX_W'(i);
      w_words[i] = req_word[i*WORD_W +: WORD_W];
    end
    w_word     = w_words[r_gnt_idx];
    w_ptr_next = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
    w_abort    = (r_state == ST_LOAD) && !req[r_gnt_idx];
    w_accept   = (r_state == ST_LOAD) && req[r_gnt_idx] && req_valid[r_gnt_idx]
                 && req_ready[r_gnt_idx];
  end

  always_comb begin
    data_to_write = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      data_to_write[i*WORD_W +: WORD_W] = r_buf[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_gnt_idx  <= '0;
      r_ptr      <= '0;
      grant      <= '0;
      req_ready  <= '0;
      write_data <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < int'(NUM_WORDS); i++) r_buf[i] <= '0;
    end else begin
      write_data <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= w_win;
            req_ready <= w_win;
            r_gnt_idx <= w_win_idx;
            r_count   <= '0;
            busy      <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A dropped request abandons the transfer; the next owner gets first pick.
          if (w_abort) begin
            grant     <= '0;
            req_ready <= '0;
            busy      <= 1'b0;
            r_ptr     <= w_ptr_next;
            r_state   <= ST_IDLE;
          end else if (w_accept) begin
            r_buf[r_count] <= w_word;
            if (r_count == CNT_W'(NUM_WORDS - 1)) begin
              req_ready  <= '0;
              write_data <= 1'b1;
              r_state    <= ST_COMMIT;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          grant   <= '0;
          done    <= 1'b1;
          r_ptr   <= w_ptr_next;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_reg_arbiter.sv
// Randomised bench for output_reg_arbiter against a transfer-level reference model.
module tb_output_reg_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [1:0]   req_valid;
  logic [31:0]  req_word;
  logic [1:0]   req_ready;
  logic [1:0]   grant;
  logic         write_data;
  logic [255:0] data_to_write;
  logic         done;
  logic         busy;

  always #5 clk = ~clk;

  output_reg_arbiter #(.NUM_REQ(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_valid     (req_valid),
    .req_word      (req_word),
    .req_ready     (req_ready),
    .grant         (grant),
    .write_data    (write_data),
    .data_to_write (data_to_write),
    .done          (done),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester-side drivers
  logic [15:0] src_q [2][$];
  logic [15:0] acc_q [2][$];
  int          vmode   [2];
  int          abort_at[2];
  logic        xtalk   [2];
  logic        tgl     [2];

  // Reference model: 0 idle, 1 loading, 2 commit, 3 done
  int          m_phase, m_owner, m_ptr, m_cnt;
  logic [15:0] m_buf [16];
  int          commit_log[$];
  int          t_grant, t_wd, t_done;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < 16; i++) m_buf[i] = 16'h0;
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = m_buf[i];
    return v;
  endfunction

  function automatic logic [255:0] acc_vec(input int k);
    logic [255:0] v = '0;
    for (int i = 0; i < acc_q[k].size() && i < 16; i++) v[i*16 +: 16] = acc_q[k][i];
    return v;
  endfunction

  task automatic model_check();
    logic [1:0] eg, er;
    eg = (m_phase == 1 || m_phase == 2) ? 2'(1 << m_owner) : 2'b00;
    er = (m_phase == 1) ? 2'(1 << m_owner) : 2'b00;
    check("grant", 256'(grant), 256'(eg));
    check("ready", 256'(req_ready), 256'(er));
    check("ctl_wd_done_busy", 256'({write_data, done, busy}),
          256'({m_phase == 2, m_phase == 3, m_phase != 0}));
    if (grant != 2'b00 && t_grant < 0) t_grant = cyc;
    if (write_data && t_wd < 0) t_wd = cyc;
    if (done && t_done < 0) t_done = cyc;
    if (m_phase == 2) begin
      check("commit_model", data_to_write, model_vec());
      check("commit_pkt", data_to_write, acc_vec(m_owner));
      check("pkt_len", 256'(acc_q[m_owner].size()), 256'(16));
      commit_log.push_back(m_owner);
      acc_q[m_owner].delete();
    end
  endtask

  task automatic model_update();
    bit found;
    if (reset) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (req != 2'b00) begin
             found = 0;
             for (int i = 0; i < 2; i++) begin
               if (!found && req[(m_ptr + i) % 2]) begin
                 m_owner = (m_ptr + i) % 2;
                 found = 1;
               end
             end
             m_cnt = 0; m_phase = 1;
           end
        1: if (!req[m_owner]) begin
             m_phase = 0; m_ptr = (m_owner + 1) % 2;
           end else if (req_valid[m_owner]) begin
             m_buf[m_cnt] = req_word[m_owner*16 +: 16];
             m_cnt++;
             if (m_cnt == 16) m_phase = 2;
           end
        2: begin m_phase = 3; m_ptr = (m_owner + 1) % 2; end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic drive_next();
    for (int k = 0; k < 2; k++) begin
      if (abort_at[k] > 0 && acc_q[k].size() == abort_at[k]) begin
        src_q[k].delete(); acc_q[k].delete(); abort_at[k] = -1;
      end
      if (src_q[k].size() != 0) begin
        req[k] = 1'b1;
        req_word[k*16 +: 16] = src_q[k][0];
        case (vmode[k])
          0: req_valid[k] = 1'b1;
          1: begin tgl[k] = ~tgl[k]; req_valid[k] = tgl[k]; end
          default: req_valid[k] = 1'($urandom_range(0, 1));
        endcase
      end else begin
        req[k] = 1'b0;
        req_valid[k] = xtalk[k];
        req_word[k*16 +: 16] = xtalk[k] ? 16'hDEAD : 16'h0000;
      end
    end
  endtask

  // One clock: drive, sample at negedge, model, return at posedge+1.
  task automatic cycle();
    drive_next();
    @(negedge clk);
    cyc++;
    model_check();
    for (int k = 0; k < 2; k++) begin
      if (req[k] && req_valid[k] && req_ready[k]) acc_q[k].push_back(src_q[k].pop_front());
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drivers();
    for (int k = 0; k < 2; k++) begin
      src_q[k].delete(); acc_q[k].delete();
      vmode[k] = 0; abort_at[k] = -1; xtalk[k] = 1'b0; tgl[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_drivers();
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic load_seq(input int k, input logic [15:0] base, input int mode);
    for (int i = 0; i < 16; i++) src_q[k].push_back(base + 16'(i));
    vmode[k] = mode; abort_at[k] = -1;
  endtask

  task automatic load_rand(input int k, input int mode);
    for (int i = 0; i < 16; i++) src_q[k].push_back(16'($urandom) & 16'h7FFF);
    vmode[k] = mode; abort_at[k] = -1;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 || m_phase != 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    if (n >= max_cyc) check("timeout", 256'(0), 256'(1));
    repeat (2) cycle();
  endtask

  task automatic mark_start();
    t_grant = -1; t_wd = -1; t_done = -1;
  endtask

  initial begin
    int t_req, n0, dead_cnt;
    logic [255:0] exp_v;

    req = '0; req_valid = '0; req_word = '0;
    clear_drivers();
    model_reset();
    mark_start();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_grant", 256'(grant), 256'(0));
    check("rst_ready", 256'(req_ready), 256'(0));
    check("rst_ctl", 256'({write_data, done, busy}), 256'(0));
    check("rst_data", data_to_write, 256'(0));
    @(posedge clk); #1;
    repeat (2) cycle();
    reset = 1'b0;

    // Single requester, back-to-back words 0..15
    mark_start();
    load_seq(0, 16'h0000, 0);
    t_req = cyc + 1;
    run_until_idle(100);
    check("s1_grant_lat", 256'(t_grant - t_req), 256'(1));
    check("s1_wd_lat", 256'(t_wd - t_req), 256'(17));
    check("s1_done_lat", 256'(t_done - t_req), 256'(18));
    for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = 16'(i);
    check("s1_data", data_to_write, exp_v);

    // Both request from reset, then again: order 0,1,0,1
    do_reset();
    commit_log.delete();
    load_seq(0, 16'hA000, 0); load_seq(1, 16'hB000, 0);
    run_until_idle(200);
    load_seq(0, 16'hA000, 0); load_seq(1, 16'hB000, 0);
    run_until_idle(200);
    check("s2_ncommit", 256'(commit_log.size()), 256'(4));
    check("s2_order", 256'({commit_log[0][1:0], commit_log[1][1:0], commit_log[2][1:0], commit_log[3][1:0]}),
          256'(8'b00_01_00_01));

    // Requester 1 with valid every other cycle
    mark_start();
    load_rand(1, 1);
    run_until_idle(200);
    check("s3_gap_lat", 256'((t_wd - t_grant == 31) || (t_wd - t_grant == 32)), 256'(1));

    // Abort requester 0 after 5 words with requester 1 pending
    commit_log.delete();
    load_rand(0, 0); load_rand(1, 2);
    abort_at[0] = 5;
    run_until_idle(300);
    check("s4_ncommit", 256'(commit_log.size()), 256'(1));
    if (commit_log.size() == 1) check("s4_owner", 256'(commit_log[0]), 256'(1));

    // Reset mid-LOAD after 8 words
    commit_log.delete();
    load_rand(0, 0);
    n0 = 0;
    while (acc_q[0].size() < 8 && n0 < 50) begin cycle(); n0++; end
    check("s5_reached8", 256'(acc_q[0].size() >= 8), 256'(1));
    reset = 1'b1;
    #1;
    check("s5_async_grant", 256'(grant), 256'(0));
    check("s5_async_ctl", 256'({req_ready, write_data, done, busy}), 256'(0));
    check("s5_async_data", data_to_write, 256'(0));
    clear_drivers();
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    check("s5_no_strobe", 256'(commit_log.size()), 256'(0));
    load_rand(0, 2);
    run_until_idle(200);
    check("s5_recover", 256'(commit_log.size()), 256'(1));

    // Cross-talk: idle requester 1 drives valid with 0xDEAD
    xtalk[1] = 1'b1;
    load_rand(0, 2);
    run_until_idle(200);
    dead_cnt = 0;
    for (int i = 0; i < 16; i++) if (data_to_write[i*16 +: 16] == 16'hDEAD) dead_cnt++;
    check("s6_no_dead", 256'(dead_cnt), 256'(0));
    xtalk[1] = 1'b0;

    // Random soak: random requester sets, valid patterns and aborts
    for (int it = 0; it < 12; it++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        if (mask[k]) begin
          load_rand(k, $urandom_range(0, 2));
          if ($urandom_range(0, 3) == 0) abort_at[k] = $urandom_range(1, 15);
        end
      end
      run_until_idle(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
